// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / data) arbiter in front of a single-port
// synchronous-read memory. Each access spends one ACCESS cycle driving the
// memory and one RESP cycle waiting for read data; arbitration happens in
// IDLE and RESP, so back-to-back accesses issue one grant every two cycles.
// Data normally wins; a starved fetch is forced through after STARVE_MAX
// consecutive losses unless a locked read-modify-write sequence owns the port.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk1,
    input  logic              rst_n,
    // Instruction fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // Load/store port
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic              d_wdone,
    output logic [DATA_W-1:0] d_rdata,
    // Pipeline control
    input  logic              halt,
    // Memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned StarveW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [StarveW-1:0] StarveMaxC = StarveW'(STARVE_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [StarveW-1:0]  starve_q, starve_d;
    logic                lock_q, lock_d;
    logic                starve_max;
    logic                win_d;
    logic                win_if;

    // Owner of the access currently in flight
    logic                owner_d_q;
    logic                store_q;

    // Registered memory-side and grant outputs, live only during ACCESS
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                if_gnt_q;
    logic                d_gnt_q;

    // Registered response outputs
    logic                if_rvalid_q;
    logic                d_rvalid_q;
    logic                d_wdone_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;

    logic                in_resp;

    assign starve_max = (starve_q == StarveMaxC);
    assign in_resp    = (state_q == StResp);

    // Next state, arbitration decision, starve counter and lock flag updates
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        lock_d   = lock_q;
        win_d    = 1'b0;
        win_if   = 1'b0;
        case (state_q)
            StIdle, StResp: begin
                if (!halt) begin
                    // A held lock keeps IF out; with no data request the lock is moot
                    if (d_req && (lock_q || !(if_req && starve_max))) begin
                        win_d = 1'b1;
                    end else if (if_req) begin
                        win_if = 1'b1;
                    end
                end
                if (win_if || !if_req) begin
                    starve_d = '0;
                end else if (win_d && !starve_max) begin
                    starve_d = starve_q + StarveW'(1);
                end
                if (win_d) begin
                    lock_d = d_lock;
                end else if (!d_req) begin
                    lock_d = 1'b0;
                end
                state_d = (win_d || win_if) ? StAccess : StIdle;
            end
            StAccess: state_d = StResp;
            default:  state_d = StIdle;
        endcase
    end

    // FSM state, arbitration bookkeeping and owner of the in-flight access
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            starve_q  <= '0;
            lock_q    <= 1'b0;
            owner_d_q <= 1'b0;
            store_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            lock_q   <= lock_d;
            if (win_d || win_if) begin
                owner_d_q <= win_d;
                store_q   <= win_d & d_we;
            end
        end
    end

    // Memory request and grant pulse: loaded at the arbitration edge, cleared one cycle later
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
        end else begin
            mem_en_q    <= win_d | win_if;
            mem_we_q    <= win_d & d_we;
            if_gnt_q    <= win_if;
            d_gnt_q     <= win_d;
            if (win_d) begin
                mem_addr_q  <= d_addr;
                mem_wdata_q <= d_wdata;
            end else if (win_if) begin
                mem_addr_q  <= if_addr;
                mem_wdata_q <= '0;
            end else begin
                mem_addr_q  <= '0;
                mem_wdata_q <= '0;
            end
        end
    end

    // Response: capture read data at the end of RESP and pulse the owner's strobe
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_wdone_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_rvalid_q <= in_resp & ~owner_d_q;
            d_rvalid_q  <= in_resp & owner_d_q & ~store_q;
            d_wdone_q   <= in_resp & owner_d_q & store_q;
            if (in_resp && !owner_d_q) begin
                if_rdata_q <= mem_rdata;
            end
            // Stores leave d_rdata untouched; it only tracks load results
            if (in_resp && owner_d_q && !store_q) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_wdone   = d_wdone_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

    // The port has exactly one owner per access
    a_one_owner: assert property (@(posedge clk1) disable iff (!rst_n) !(if_gnt && d_gnt));

    // The memory is only driven while an access is in its ACCESS cycle
    a_mem_quiet: assert property (@(posedge clk1) disable iff (!rst_n)
        !mem_en |-> (!mem_we && mem_addr == '0 && mem_wdata == '0));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a cycle-scheduled transaction model.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned MemWords   = 1 << ADDR_W;

    logic              clk1 = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic              d_lock = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_gnt;
    logic              d_rvalid;
    logic              d_wdone;
    logic [DATA_W-1:0] d_rdata;
    logic              halt = 1'b0;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk1     (clk1),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_lock   (d_lock),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_wdone  (d_wdone),
        .d_rdata  (d_rdata),
        .halt     (halt),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial forever #5 clk1 = ~clk1;

    function automatic logic [31:0] init_word(int i);
        if (i == 5) return 32'h2000_0001;
        return 32'hA500_0000 ^ (32'(i) * 32'h0001_0103);
    endfunction

    // Environment memory: synchronous read, data valid the cycle after mem_en
    logic [DATA_W-1:0] mem [MemWords];
    initial begin
        mem_rdata = '0;
        for (int i = 0; i < int'(MemWords); i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk1);
            if (mem_en) begin
                if (mem_we) mem[mem_addr] <= mem_wdata;
                else        mem_rdata <= mem[mem_addr];
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic              if_gnt;
        logic              d_gnt;
        logic              if_rvalid;
        logic              d_rvalid;
        logic              d_wdone;
        logic              mem_en;
        logic              mem_we;
        logic [ADDR_W-1:0] mem_addr;
        logic [DATA_W-1:0] mem_wdata;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    exp_t              ring [8];          // expected outputs, indexed by cycle mod 8
    logic [DATA_W-1:0] ref_mem [MemWords];
    int                cyc;               // index of the current clock cycle
    int                free_at;           // first cycle at which arbitration may happen
    int unsigned       m_starve;
    bit                m_lock;
    logic [DATA_W-1:0] exp_if_rdata;
    logic [DATA_W-1:0] exp_d_rdata;
    bit                pw_valid;          // store waiting to reach memory
    int                pw_cycle;
    logic [ADDR_W-1:0] pw_addr;
    logic [DATA_W-1:0] pw_data;

    int checks;
    int errors;
    bit grant_log [$];                    // 1 = IF grant, 0 = data grant
    int wdone_cnt;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ring[i] = '0;
        free_at      = 0;
        m_starve     = 0;
        m_lock       = 1'b0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        pw_valid     = 1'b0;
    endtask

    // Decide the winner for an arbitration in cycle cyc and schedule its effects
    task automatic arbitrate();
        bit d_win;
        bit i_win;
        int k;
        d_win = 1'b0;
        i_win = 1'b0;
        if (!halt) begin
            if (d_req && (m_lock || !(if_req && m_starve == STARVE_MAX))) d_win = 1'b1;
            else if (if_req) i_win = 1'b1;
        end
        if (i_win || !if_req) m_starve = 0;
        else if (d_win && m_starve < STARVE_MAX) m_starve++;
        if (d_win) m_lock = d_lock;
        else if (!d_req) m_lock = 1'b0;
        if (d_win || i_win) begin
            k = (cyc + 1) % 8;
            ring[k].if_gnt    = i_win;
            ring[k].d_gnt     = d_win;
            ring[k].mem_en    = 1'b1;
            ring[k].mem_we    = d_win & d_we;
            ring[k].mem_addr  = d_win ? d_addr : if_addr;
            ring[k].mem_wdata = d_win ? d_wdata : '0;
            k = (cyc + 3) % 8;
            if (i_win) begin
                ring[k].if_rvalid = 1'b1;
                ring[k].rdata     = ref_mem[if_addr];
            end else if (d_we) begin
                ring[k].d_wdone = 1'b1;
                pw_valid = 1'b1;
                pw_cycle = cyc + 1;
                pw_addr  = d_addr;
                pw_data  = d_wdata;
            end else begin
                ring[k].d_rvalid = 1'b1;
                ring[k].rdata    = ref_mem[d_addr];
            end
            free_at = cyc + 2;
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else begin
            if (pw_valid && pw_cycle == cyc) begin
                ref_mem[pw_addr] = pw_data;
                pw_valid = 1'b0;
            end
            if (cyc >= free_at) arbitrate();
        end
        cyc++;
    endtask

    task automatic compare();
        exp_t e;
        if (!rst_n) model_reset();
        e = ring[cyc % 8];
        if (e.if_rvalid) exp_if_rdata = e.rdata;
        if (e.d_rvalid)  exp_d_rdata  = e.rdata;
        check("if_gnt",    64'(if_gnt),    64'(e.if_gnt));
        check("d_gnt",     64'(d_gnt),     64'(e.d_gnt));
        check("if_rvalid", 64'(if_rvalid), 64'(e.if_rvalid));
        check("d_rvalid",  64'(d_rvalid),  64'(e.d_rvalid));
        check("d_wdone",   64'(d_wdone),   64'(e.d_wdone));
        check("mem_en",    64'(mem_en),    64'(e.mem_en));
        check("mem_we",    64'(mem_we),    64'(e.mem_we));
        check("mem_addr",  64'(mem_addr),  64'(e.mem_addr));
        check("mem_wdata", 64'(mem_wdata), 64'(e.mem_wdata));
        check("if_rdata",  64'(if_rdata),  64'(exp_if_rdata));
        check("d_rdata",   64'(d_rdata),   64'(exp_d_rdata));
        ring[cyc % 8] = '0;
    endtask

    // One clock: model sees inputs at the edge, outputs compared at the falling edge
    task automatic tick();
        @(posedge clk1);
        model_step();
        @(negedge clk1);
        compare();
        if (if_gnt)  grant_log.push_back(1'b1);
        if (d_gnt)   grant_log.push_back(1'b0);
        if (d_wdone) wdone_cnt++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_d_gnt(string name);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (d_gnt) break;
        end
        check(name, 64'(d_gnt), 64'(1));
    endtask

    task automatic drop_all();
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        d_lock = 1'b0;
        halt   = 1'b0;
    endtask

    initial begin
        logic [9:0] pat10;
        logic [5:0] pat6;
        int         g0;
        bit         rv_seen;

        checks = 0;
        errors = 0;
        cyc    = 0;
        wdone_cnt = 0;
        for (int i = 0; i < int'(MemWords); i++) ref_mem[i] = init_word(i);
        model_reset();

        // Reset state
        repeat (3) tick();
        check("reset_d_rdata", 64'(d_rdata), 64'(0));
        rst_n = 1'b1;

        // Single fetch
        if_req  = 1'b1;
        if_addr = ADDR_W'(5);
        tick();
        check("fetch_gnt",      64'(if_gnt),   64'(1));
        check("fetch_mem_addr", 64'(mem_addr), 64'(5));
        check("fetch_mem_en",   64'(mem_en),   64'(1));
        if_req = 1'b0;
        tick();
        tick();
        check("fetch_rvalid", 64'(if_rvalid), 64'(1));
        check("fetch_rdata",  64'(if_rdata),  64'(32'h2000_0001));

        // Reset in the RESP cycle of a fetch
        if_req  = 1'b1;
        if_addr = ADDR_W'(6);
        tick();
        if_req = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_ctrl_zero", 64'({if_gnt, if_rvalid, d_gnt, d_rvalid, d_wdone, mem_en, mem_we}),
              64'(0));
        check("rst_if_rdata_zero", 64'(if_rdata),  64'(0));
        check("rst_mem_addr_zero", 64'(mem_addr),  64'(0));
        rv_seen = 1'b0;
        repeat (2) begin
            tick();
            rv_seen |= if_rvalid;
        end
        rst_n   = 1'b1;
        if_req  = 1'b1;
        if_addr = ADDR_W'(6);
        tick();
        rv_seen |= if_rvalid;
        check("rst_no_rvalid",   64'(rv_seen), 64'(0));
        check("rst_first_grant", 64'(if_gnt),  64'(1));
        drop_all();
        repeat (3) tick();

        // Contention: four data grants then one fetch, repeating
        do_reset();
        grant_log.delete();
        if_req  = 1'b1;
        if_addr = ADDR_W'(17);
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = ADDR_W'(9);
        repeat (20) tick();
        check("contention_count", 64'(grant_log.size()), 64'(10));
        pat10 = '0;
        for (int i = 0; i < 10 && i < grant_log.size(); i++) pat10[i] = grant_log[i];
        check("contention_order", 64'(pat10), 64'(10'b10_0001_0000));
        drop_all();
        repeat (4) tick();

        // Locked read-modify-write while IF is starved
        do_reset();
        grant_log.delete();
        wdone_cnt = 0;
        if_req  = 1'b1;
        if_addr = ADDR_W'(64);
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = ADDR_W'(20);
        repeat (3) wait_d_gnt("lock_pre_gnt");
        d_lock = 1'b1;
        d_addr = ADDR_W'(3);
        wait_d_gnt("lock_load_gnt");
        d_we    = 1'b1;
        d_lock  = 1'b0;
        d_wdata = 32'hDEAD_BEEF;
        wait_d_gnt("lock_store_gnt");
        d_req = 1'b0;
        d_we  = 1'b0;
        repeat (6) tick();
        pat6 = '0;
        for (int i = 0; i < 6 && i < grant_log.size(); i++) pat6[i] = grant_log[i];
        check("lock_order", 64'(pat6),      64'(6'b10_0000));
        check("lock_wdone", 64'(wdone_cnt), 64'(1));
        check("lock_mem3",  64'(mem[3]),    64'(32'hDEAD_BEEF));
        drop_all();
        repeat (4) tick();

        // Halt during the ACCESS cycle of a store
        do_reset();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = ADDR_W'(7);
        d_wdata = 32'hCAFE_0007;
        wait_d_gnt("halt_store_gnt");
        halt      = 1'b1;
        wdone_cnt = 0;
        d_we      = 1'b0;
        d_addr    = ADDR_W'(8);
        if_req    = 1'b1;
        if_addr   = ADDR_W'(2);
        g0 = grant_log.size();
        repeat (10) tick();
        check("halt_wdone",    64'(wdone_cnt),        64'(1));
        check("halt_mem7",     64'(mem[7]),           64'(32'hCAFE_0007));
        check("halt_no_grant", 64'(grant_log.size()), 64'(g0));
        halt = 1'b0;
        repeat (4) tick();
        drop_all();
        repeat (4) tick();

        // Randomized traffic with occasional halt and reset
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (!if_req || if_gnt) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = ADDR_W'($urandom_range(0, 31));
            end
            if (!d_req || d_gnt) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = ($urandom_range(0, 1) == 1);
                d_lock  = ($urandom_range(0, 3) == 0);
                d_addr  = ADDR_W'($urandom_range(0, 31));
                d_wdata = $urandom();
            end
            halt = ($urandom_range(0, 15) == 0);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
        end
        rst_n = 1'b1;
        drop_all();
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
